timekeeper_core: RTL and testbench
==================================

# timekeeper_core

Parametrised timekeeping core for the watch: a prescaler, an HH:MM:SS time-of-day counter, and N programmable alarm channels with snooze and auto-timeout. It takes one-cycle adjust pulses from the mode FSM. It feeds binary time and alarm status to the seven-segment display and buzzer logic. It supersedes the fixed clock divider plus single time counter pairing used today.

## Interface

Parameters:
- `CLK_DIV`, 32768: clk cycles per second.
- `N_ALARM`, 2: alarm channel count, ≥1.
- `SNOOZE_MIN`, 5: snooze length in minutes, 1–59.
- `RING_SEC`, 60: seconds a channel rings before auto-clear, ≥1.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `run` in 1: enables the prescaler and time advance.
- `inc_m`, `dec_m`, `inc_h`, `dec_h` in 1 each: single-cycle adjust pulses.
- `alarm_wr` in 1: write strobe for the selected alarm channel.
- `alarm_sel` in $clog2(N_ALARM) (min 1): channel to write.
- `alarm_h` in 6: alarm hour, 0–23.
- `alarm_m` in 6: alarm minute, 0–59.
- `alarm_en` in 1: enable bit written with the alarm.
- `snooze` in 1: pulse; applies to all RINGING channels.
- `dismiss` in 1: pulse; applies to all non-IDLE channels.
- `mode_12h` in 1: selects the 12-hour display format.
- `seconds`, `minutes`, `hours` out 6 each: binary time, 24-hour.
- `disp_hours` out 6: hours in display format.
- `pm` out 1: afternoon flag.
- `tick` out 1: one-cycle pulse per second.
- `ringing` out N_ALARM: per-channel ringing flags.
- `buzz` out 1: OR of `ringing`.

## Operation

**Prescaler**
- Counts 0..CLK_DIV-1 while `run`=1; frozen while `run`=0.
- `tick` = `run` && count==CLK_DIV-1.

**Time counter**
- On `tick`, advance seconds with carry: 59→0 with minute++; 59:59→hour++; 23:59:59→00:00:00.
- Adjust pulses act only on their own field, with no carry: minutes wrap 59↔0, hours wrap 23↔0; seconds are untouched.
- Priority when several pulses arrive together: inc_h > dec_h > inc_m > dec_m. Only one adjustment is applied.
- If any adjust pulse is high in a tick cycle, that tick is dropped and the prescaler still wraps.

**Display format**
- `mode_12h`=0: `disp_hours`=`hours`.
- `mode_12h`=1: hour 0→12; hours 13–23→h-12; otherwise unchanged.
- `pm` = hours≥12, regardless of mode.

**Alarm channels**
- Per-channel registers: {en, h, m, snooze_h, snooze_m, ring_cnt}.
- `alarm_wr` with h≤23 and m≤59 loads the registers and forces the channel to IDLE. Writes with out-of-range values are ignored entirely.
- Channel FSM:
  - IDLE→RINGING: on a tick whose next time equals en && h:m:00.
  - RINGING→IDLE: on `dismiss`, or after RING_SEC ticks in RINGING (ring_cnt resets on entry).
  - RINGING→SNOOZED: on `snooze`; latches snooze target = next time + SNOOZE_MIN minutes, mod 24 h.
  - SNOOZED→RINGING: on a tick whose next time equals snooze_h:snooze_m:00.
  - SNOOZED→IDLE: on `dismiss`, or if en is cleared by a write.
- Same-cycle conflicts:
  - `dismiss` beats `snooze`.
  - `snooze` beats ring timeout.
  - `alarm_wr` beats all of the above for the written channel.
- Adjust pulses never trigger a match; matches are evaluated only on ticks.
- `ringing[i]` = channel i is in RINGING.

## Timing

- Reset, on the first edge with `rst`=1:
  - time = 00:00:00, prescaler = 0, all channels IDLE with en=0, h=m=0.
  - Outputs: `tick`=0, `ringing`=0, `buzz`=0, `disp_hours`=0, `pm`=0.
  - Reset mid-ring clears the channel immediately.
- `tick` is combinational from the prescaler. Time outputs update on the edge ending the tick cycle.
- Alarm matching compares against the next-state time, so `ringing` rises in the same cycle the matching time first appears on the outputs (1-cycle latency from `tick`).
- `snooze`, `dismiss` and `alarm_wr` take effect on the next edge.
- `disp_hours`, `pm` and `buzz` are combinational from registers.

## Structure

- Shared package `watch_pkg`:
  - Constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - `alarm_state_t` enum {IDLE, RINGING, SNOOZED}.
  - Time-field width TW=6.
- Sub-module `alarm_channel`: holds the registers and FSM for one channel, instantiated N_ALARM times with a generate loop. Its inputs are the next-state time, `tick`, `snooze`, `dismiss`, and the decoded write strobe.

## Test plan

- CLK_DIV=4, `run`=1: `tick` fires every 4th cycle. Adjust to 23:59:00; after 60 ticks time reads 00:00:00.
- Alarm ch0 = 07:30, en=1; set 07:29:00, run 60 ticks → `ringing`=01 and `buzz`=1 exactly as 07:30:00 appears. With RING_SEC=60, auto-clears at 07:31:00.
- Ringing at 07:30:10, pulse `snooze` → `ringing`=0; re-rings at 07:35:00. A `dismiss`+`snooze` pulse in the same cycle → IDLE, no re-ring.
- `mode_12h`=1: hours 0→disp 12/pm 0; 12→12/pm 1; 13→1/pm 1; 23→11/pm 1.
- At 00:00:59, `inc_m` in the tick cycle → 00:01:59, tick dropped. `dec_h` at hour 0 → 23. `inc_h`+`dec_m` together → only hour increments.
- `alarm_wr` with h=24 → registers unchanged. `rst` during RINGING → all outputs 0 after one edge, and the alarm is disabled.

Source files
------------

// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared time-field constants and alarm channel state type
package watch_pkg;

    localparam int TW = 6;

    localparam logic [TW-1:0] SEC_MAX  = 6'd59;
    localparam logic [TW-1:0] MIN_MAX  = 6'd59;
    localparam logic [TW-1:0] HOUR_MAX = 6'd23;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/alarm_channel.sv
// rtl/alarm_channel.sv - one alarm channel: registers plus IDLE/RINGING/SNOOZED FSM
module alarm_channel
    import watch_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [TW-1:0] nxt_h,
    input  logic [TW-1:0] nxt_m,
    input  logic [TW-1:0] nxt_s,
    input  logic          snooze,
    input  logic          dismiss,
    input  logic          wr,
    input  logic [TW-1:0] wr_h,
    input  logic [TW-1:0] wr_m,
    input  logic          wr_en,
    output logic          ringing
);

    localparam int RW = $clog2(RING_SEC + 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

    alarm_state_t  state;
    logic          en;
    logic [TW-1:0] h, m, snooze_h, snooze_m;
    logic [RW-1:0] ring_cnt;

    logic [TW:0]   sum_m;
    logic [TW-1:0] tgt_h, tgt_m;
    logic          at_minute, alarm_hit, snooze_hit;

    // Snooze target is taken from the time about to be shown, wrapping past midnight.
    always_comb begin
        sum_m = {1'b0, nxt_m} + (TW+1)'(SNOOZE_MIN);
        tgt_h = nxt_h;
        tgt_m = sum_m[TW-1:0];
        if (sum_m > {1'b0, MIN_MAX}) begin
            tgt_m = TW'(sum_m - (TW+1)'(60));
            tgt_h = (nxt_h == HOUR_MAX) ? '0 : nxt_h + 6'd1;
        end
    end

    assign at_minute  = tick && (nxt_s == '0);
    assign alarm_hit  = at_minute && en && (nxt_h == h) && (nxt_m == m);
    assign snooze_hit = at_minute && (nxt_h == snooze_h) && (nxt_m == snooze_m);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            en       <= 1'b0;
            h        <= '0;
            m        <= '0;
            snooze_h <= '0;
            snooze_m <= '0;
            ring_cnt <= '0;
        end else if (wr) begin
            state    <= IDLE;
            en       <= wr_en;
            h        <= wr_h;
            m        <= wr_m;
            ring_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (alarm_hit) begin
                        state    <= RINGING;
                        ring_cnt <= '0;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state <= IDLE;
                    end else if (snooze) begin
                        state    <= SNOOZED;
                        snooze_h <= tgt_h;
                        snooze_m <= tgt_m;
                    end else if (tick) begin
                        if (ring_cnt == RING_LAST) state <= IDLE;
                        else                       ring_cnt <= ring_cnt + RW'(1);
                    end
                end
                SNOOZED: begin
                    if (dismiss) begin
                        state <= IDLE;
                    end else if (snooze_hit) begin
                        state    <= RINGING;
                        ring_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ringing = (state == RINGING);

endmodule

// File: rtl/timekeeper_core.sv
// rtl/timekeeper_core.sv - prescaler, HH:MM:SS counter, display format and alarm channels
module timekeeper_core
    import watch_pkg::*;
#(
    parameter int CLK_DIV    = 32768,
    parameter int N_ALARM    = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    localparam int SW        = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               inc_m,
    input  logic               dec_m,
    input  logic               inc_h,
    input  logic               dec_h,
    input  logic               alarm_wr,
    input  logic [SW-1:0]      alarm_sel,
    input  logic [TW-1:0]      alarm_h,
    input  logic [TW-1:0]      alarm_m,
    input  logic               alarm_en,
    input  logic               snooze,
    input  logic               dismiss,
    input  logic               mode_12h,
    output logic [TW-1:0]      seconds,
    output logic [TW-1:0]      minutes,
    output logic [TW-1:0]      hours,
    output logic [TW-1:0]      disp_hours,
    output logic               pm,
    output logic               tick,
    output logic [N_ALARM-1:0] ringing,
    output logic               buzz
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] pre_cnt;
    logic [TW-1:0] nxt_s, nxt_m, nxt_h;
    logic          adj_any, tick_eff, wr_ok;

    always_ff @(posedge clk) begin
        if (rst)      pre_cnt <= '0;
        else if (run) pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + CW'(1);
    end

    assign tick     = run && (pre_cnt == PRE_LAST);
    assign adj_any  = inc_m | dec_m | inc_h | dec_h;
    // An adjust pulse swallows a coincident tick, so alarms never see it either.
    assign tick_eff = tick && !adj_any;

    always_comb begin
        nxt_s = seconds;
        nxt_m = minutes;
        nxt_h = hours;
        if (inc_h) begin
            nxt_h = (hours == HOUR_MAX) ? '0 : hours + 6'd1;
        end else if (dec_h) begin
            nxt_h = (hours == '0) ? HOUR_MAX : hours - 6'd1;
        end else if (inc_m) begin
            nxt_m = (minutes == MIN_MAX) ? '0 : minutes + 6'd1;
        end else if (dec_m) begin
            nxt_m = (minutes == '0) ? MIN_MAX : minutes - 6'd1;
        end else if (tick) begin
            if (seconds == SEC_MAX) begin
                nxt_s = '0;
                if (minutes == MIN_MAX) begin
                    nxt_m = '0;
                    nxt_h = (hours == HOUR_MAX) ? '0 : hours + 6'd1;
                end else begin
                    nxt_m = minutes + 6'd1;
                end
            end else begin
                nxt_s = seconds + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seconds <= '0;
            minutes <= '0;
            hours   <= '0;
        end else begin
            seconds <= nxt_s;
            minutes <= nxt_m;
            hours   <= nxt_h;
        end
    end

    always_comb begin
        disp_hours = hours;
        if (mode_12h) begin
            if (hours == '0)         disp_hours = 6'd12;
            else if (hours > 6'd12)  disp_hours = hours - 6'd12;
        end
    end

    assign pm    = (hours >= 6'd12);
    assign wr_ok = alarm_wr && (alarm_h <= HOUR_MAX) && (alarm_m <= MIN_MAX);

    for (genvar i = 0; i < N_ALARM; i++) begin : g_alarm
        alarm_channel #(
            .SNOOZE_MIN (SNOOZE_MIN),
            .RING_SEC   (RING_SEC)
        ) u_alarm_channel (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick_eff),
            .nxt_h   (nxt_h),
            .nxt_m   (nxt_m),
            .nxt_s   (nxt_s),
            .snooze  (snooze),
            .dismiss (dismiss),
            .wr      (wr_ok && (alarm_sel == SW'(i))),
            .wr_h    (alarm_h),
            .wr_m    (alarm_m),
            .wr_en   (alarm_en),
            .ringing (ringing[i])
        );
    end

    assign buzz = |ringing;

endmodule

// File: tb/tb_timekeeper_core.sv
// tb/tb_timekeeper_core.sv - directed self-checking bench for timekeeper_core
module tb_timekeeper_core;

    logic       clk = 1'b0;
    logic       rst, run, inc_m, dec_m, inc_h, dec_h;
    logic       alarm_wr, alarm_en, snooze, dismiss, mode_12h;
    logic [0:0] alarm_sel;
    logic [5:0] alarm_h, alarm_m;
    logic [5:0] seconds, minutes, hours, disp_hours;
    logic       pm, tick, buzz;
    logic [1:0] ringing;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    timekeeper_core #(
        .CLK_DIV    (4),
        .N_ALARM    (2),
        .SNOOZE_MIN (5),
        .RING_SEC   (60)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .inc_m      (inc_m),
        .dec_m      (dec_m),
        .inc_h      (inc_h),
        .dec_h      (dec_h),
        .alarm_wr   (alarm_wr),
        .alarm_sel  (alarm_sel),
        .alarm_h    (alarm_h),
        .alarm_m    (alarm_m),
        .alarm_en   (alarm_en),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .mode_12h   (mode_12h),
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .disp_hours (disp_hours),
        .pm         (pm),
        .tick       (tick),
        .ringing    (ringing),
        .buzz       (buzz)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // kind: 0 inc_h, 1 dec_h, 2 inc_m, 3 dec_m
    task automatic adjust(input int kind, input int n);
        for (int i = 0; i < n; i++) begin
            case (kind)
                0: inc_h = 1'b1;
                1: dec_h = 1'b1;
                2: inc_m = 1'b1;
                default: dec_m = 1'b1;
            endcase
            step();
            {inc_h, dec_h, inc_m, dec_m} = '0;
        end
    endtask

    task automatic wait_tick();
        int k = 0;
        while (tick !== 1'b1 && k < 16) begin
            step();
            k++;
        end
        if (tick !== 1'b1) expect_eq("tick_timeout", {31'd0, tick}, 1);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            step();
        end
    endtask

    task automatic write_alarm(input int sel, input int h, input int m, input logic en);
        alarm_sel = sel[0:0];
        alarm_h   = h[5:0];
        alarm_m   = m[5:0];
        alarm_en  = en;
        alarm_wr  = 1'b1;
        step();
        alarm_wr  = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        expect_eq({tag, "_h"}, {26'd0, hours}, h);
        expect_eq({tag, "_m"}, {26'd0, minutes}, m);
        expect_eq({tag, "_s"}, {26'd0, seconds}, s);
    endtask

    initial begin
        int k;
        {run, inc_m, dec_m, inc_h, dec_h, alarm_wr, alarm_en, snooze, dismiss, mode_12h} = '0;
        alarm_sel = '0;
        alarm_h   = '0;
        alarm_m   = '0;
        do_reset();

        check_time("rst", 0, 0, 0);
        expect_eq("rst_tick", {31'd0, tick}, 0);
        expect_eq("rst_ringing", {30'd0, ringing}, 0);
        expect_eq("rst_buzz", {31'd0, buzz}, 0);
        expect_eq("rst_disp", {26'd0, disp_hours}, 0);
        expect_eq("rst_pm", {31'd0, pm}, 0);

        // midnight rollover and hour/minute wrap on decrement
        adjust(1, 1);
        expect_eq("dec_h_wrap", {26'd0, hours}, 23);
        adjust(3, 1);
        check_time("set_2359", 23, 59, 0);
        run = 1'b1;
        run_ticks(60);
        check_time("rollover", 0, 0, 0);
        wait_tick();
        step();
        k = 1;
        while (tick !== 1'b1 && k < 16) begin
            step();
            k++;
        end
        expect_eq("tick_period", k, 4);

        // 12-hour display and adjust priority
        do_reset();
        mode_12h = 1'b1;
        #1;
        expect_eq("disp_h0", {26'd0, disp_hours}, 12);
        expect_eq("pm_h0", {31'd0, pm}, 0);
        adjust(0, 12);
        expect_eq("disp_h12", {26'd0, disp_hours}, 12);
        expect_eq("pm_h12", {31'd0, pm}, 1);
        adjust(0, 1);
        expect_eq("disp_h13", {26'd0, disp_hours}, 1);
        expect_eq("pm_h13", {31'd0, pm}, 1);
        adjust(0, 10);
        expect_eq("disp_h23", {26'd0, disp_hours}, 11);
        expect_eq("pm_h23", {31'd0, pm}, 1);
        mode_12h = 1'b0;
        #1;
        expect_eq("disp_24h", {26'd0, disp_hours}, 23);
        adjust(0, 1);
        expect_eq("inc_h_wrap", {26'd0, hours}, 0);
        inc_h = 1'b1;
        dec_m = 1'b1;
        step();
        {inc_h, dec_m} = '0;
        check_time("prio", 1, 0, 0);

        // adjust in a tick cycle drops the tick
        do_reset();
        run = 1'b1;
        run_ticks(59);
        check_time("at_0059", 0, 0, 59);
        wait_tick();
        inc_m = 1'b1;
        step();
        inc_m = 1'b0;
        check_time("drop_tick", 0, 1, 59);

        // alarm ring and auto-clear
        do_reset();
        write_alarm(0, 7, 30, 1'b1);
        adjust(0, 7);
        adjust(2, 29);
        run = 1'b1;
        run_ticks(59);
        expect_eq("pre_ring", {30'd0, ringing}, 0);
        run_ticks(1);
        check_time("ring_at", 7, 30, 0);
        expect_eq("ring_on", {30'd0, ringing}, 1);
        expect_eq("buzz_on", {31'd0, buzz}, 1);
        run_ticks(59);
        expect_eq("ring_hold", {30'd0, ringing}, 1);
        run_ticks(1);
        check_time("autoclr_at", 7, 31, 0);
        expect_eq("autoclr", {30'd0, ringing}, 0);

        // snooze then re-ring, then dismiss beating snooze
        run = 1'b0;
        adjust(3, 2);
        run = 1'b1;
        run_ticks(60);
        expect_eq("ring2_on", {30'd0, ringing}, 1);
        run_ticks(10);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        expect_eq("snoozed", {30'd0, ringing}, 0);
        run_ticks(289);
        check_time("pre_rering", 7, 34, 59);
        expect_eq("pre_rering", {30'd0, ringing}, 0);
        run_ticks(1);
        check_time("rering_at", 7, 35, 0);
        expect_eq("rering", {30'd0, ringing}, 1);
        snooze  = 1'b1;
        dismiss = 1'b1;
        step();
        {snooze, dismiss} = '0;
        expect_eq("dismiss_win", {30'd0, ringing}, 0);
        run_ticks(300);
        check_time("no_rering_at", 7, 40, 0);
        expect_eq("no_rering", {30'd0, ringing}, 0);

        // out-of-range write ignored, reset mid-ring disables alarm
        write_alarm(0, 24, 0, 1'b0);
        run = 1'b0;
        adjust(3, 11);
        run = 1'b1;
        run_ticks(60);
        expect_eq("bad_wr_ignored", {30'd0, ringing}, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_time("rst_ring", 0, 0, 0);
        expect_eq("rst_ring_ringing", {30'd0, ringing}, 0);
        expect_eq("rst_ring_buzz", {31'd0, buzz}, 0);
        expect_eq("rst_ring_tick", {31'd0, tick}, 0);
        run = 1'b0;
        write_alarm(1, 7, 31, 1'b1);
        adjust(0, 7);
        adjust(2, 29);
        run = 1'b1;
        run_ticks(60);
        check_time("post_rst_at", 7, 30, 0);
        expect_eq("alarm_disabled", {30'd0, ringing}, 0);
        run_ticks(60);
        expect_eq("ch1_ring", {30'd0, ringing}, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
